// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and widths for the data-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 14;
  localparam int DMEM_DATA_W = 256;
  localparam int DMEM_BE_W   = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  // Tag that travels alongside each RAM access until its data returns.
  typedef struct packed {
    logic is_read;
    logic owner;
  } ret_tag_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundles both requester ports and the dmem RAM port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req and fields until their gnt.
interface dmem_port_arbiter_if;
  import dmem_arb_pkg::*;

  logic                   r0_req,      r1_req;
  logic                   r0_we,       r1_we;
  logic                   r0_lock,     r1_lock;
  logic [DMEM_ADDR_W-1:0] r0_addr,     r1_addr;
  logic [DMEM_BE_W-1:0]   r0_byteena,  r1_byteena;
  logic [DMEM_DATA_W-1:0] r0_wdata,    r1_wdata;
  logic                   r0_gnt,      r1_gnt;
  logic                   r0_rvalid,   r1_rvalid;
  logic [DMEM_DATA_W-1:0] rdata;

  logic [DMEM_DATA_W-1:0] ram_readData;
  logic                   ram_rden;
  logic                   ram_wren;
  logic [DMEM_ADDR_W-1:0] ram_address;
  logic [DMEM_BE_W-1:0]   ram_byteena;
  logic [DMEM_DATA_W-1:0] ram_writeData;

  // Arbiter side.
  modport slave (
    input  r0_req, r0_we, r0_lock, r0_addr, r0_byteena, r0_wdata,
    input  r1_req, r1_we, r1_lock, r1_addr, r1_byteena, r1_wdata,
    input  ram_readData,
    output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rdata,
    output ram_rden, ram_wren, ram_address, ram_byteena, ram_writeData
  );

  // Requester / memory side.
  modport master (
    output r0_req, r0_we, r0_lock, r0_addr, r0_byteena, r0_wdata,
    output r1_req, r1_we, r1_lock, r1_addr, r1_byteena, r1_wdata,
    output ram_readData,
    input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rdata,
    input  ram_rden, ram_wren, ram_address, ram_byteena, ram_writeData
  );

endinterface

// File: rtl/dmem_port_arbiter_ret_pipe.sv
// Delay line carrying {is_read, owner} tags to align with RAM read data.
// Latency: DEPTH cycles from tag_i to tag_o.
// Backpressure: none; advances every cycle, cleared by rst_n.
module dmem_read_return_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  ret_tag_t tag_i,
  output ret_tag_t tag_o
);

  ret_tag_t pipe_q [DEPTH];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the dmem RAM port between VLSU (r0) and loader/DMA (r1).
// Latency: grant is combinational; read data returns READ_LATENCY cycles after grant.
// Backpressure: requester holds req until gnt; locked bursts capped at MAX_BURST when contended.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 8
) (
  input  logic clk,
  input  logic reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             gnt0, gnt1;
  logic             own, own_req, oth_req, own_lock;
  ret_tag_t         tag_in, tag_out;

  // Arbitration state; last_gnt starts at 1 so r0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign own      = (state_q == ARB_LOCK1);
  assign own_req  = own ? bus.r1_req  : bus.r0_req;
  assign oth_req  = own ? bus.r0_req  : bus.r1_req;
  assign own_lock = own ? bus.r1_lock : bus.r0_lock;

  // Grant selection and next state; no grant while reset is held.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    if (reset) begin
      if (state_q == ARB_IDLE) begin
        gnt0 = bus.r0_req & (~bus.r1_req | last_gnt_q);
        gnt1 = bus.r1_req & ~gnt0;
        if (gnt0) begin
          last_gnt_d = 1'b0;
          if (bus.r0_lock) begin
            state_d     = ARB_LOCK0;
            burst_cnt_d = CNT_W'(1);
          end
        end else if (gnt1) begin
          last_gnt_d = 1'b1;
          if (bus.r1_lock) begin
            state_d     = ARB_LOCK1;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end else if (!own_req || (burst_cnt_q == MAX_CNT && oth_req)) begin
        // Owner went away or the cap was hit under contention: release, no grant.
        state_d     = ARB_IDLE;
        burst_cnt_d = '0;
      end else begin
        gnt0       = ~own;
        gnt1       = own;
        last_gnt_d = own;
        if (burst_cnt_q != MAX_CNT) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if (!own_lock) begin
          state_d     = ARB_IDLE;
          burst_cnt_d = '0;
        end
      end
    end
  end

  // Mux the granted requester onto the RAM port; idle port drives zeros.
  always_comb begin
    bus.ram_rden      = 1'b0;
    bus.ram_wren      = 1'b0;
    bus.ram_address   = '0;
    bus.ram_byteena   = '0;
    bus.ram_writeData = '0;
    if (gnt0) begin
      bus.ram_rden      = ~bus.r0_we;
      bus.ram_wren      = bus.r0_we;
      bus.ram_address   = bus.r0_addr;
      bus.ram_byteena   = bus.r0_byteena;
      bus.ram_writeData = bus.r0_wdata;
    end else if (gnt1) begin
      bus.ram_rden      = ~bus.r1_we;
      bus.ram_wren      = bus.r1_we;
      bus.ram_address   = bus.r1_addr;
      bus.ram_byteena   = bus.r1_byteena;
      bus.ram_writeData = bus.r1_wdata;
    end
  end

  assign tag_in.is_read = (gnt0 & ~bus.r0_we) | (gnt1 & ~bus.r1_we);
  assign tag_in.owner   = gnt1;

  dmem_read_return_pipe #(.DEPTH(READ_LATENCY)) u_ret_pipe (
    .clk   (clk),
    .rst_n (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = tag_out.is_read & ~tag_out.owner;
  assign bus.r1_rvalid = tag_out.is_read &  tag_out.owner;
  assign bus.rdata     = bus.ram_readData;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 2-cycle-latency RAM model.
// Latency: n/a.
// Backpressure: requesters hold req until gnt.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(.READ_LATENCY(2), .MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write at the grant edge, read data valid two cycles after grant.
  logic [DMEM_DATA_W-1:0] mem [16384];
  logic [DMEM_DATA_W-1:0] rd_stage;
  always @(posedge clk) begin
    if (bus.ram_wren)
      for (int b = 0; b < DMEM_BE_W; b++)
        if (bus.ram_byteena[b]) mem[bus.ram_address][b*8 +: 8] <= bus.ram_writeData[b*8 +: 8];
    if (bus.ram_rden) rd_stage <= mem[bus.ram_address];
    bus.ram_readData <= rd_stage;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r0_req, r0_we;
    logic [13:0] r0_addr;
    logic        r1_req, r1_we;
    logic [13:0] r1_addr;
    logic [31:0] be;
    logic [255:0] wd;
    logic        g0, g1, v0, v1, chk_rd;
    logic [255:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic q0, w0, input logic [13:0] a0,
                              input logic q1, w1, input logic [13:0] a1,
                              input logic [31:0] be, input logic [255:0] wd,
                              input logic g0, g1, v0, v1, c, input logic [255:0] rd);
    vec_t v;
    v.r0_req = q0; v.r0_we = w0; v.r0_addr = a0;
    v.r1_req = q1; v.r1_we = w1; v.r1_addr = a1;
    v.be = be; v.wd = wd;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.chk_rd = c; v.rd = rd;
    return v;
  endfunction

  task automatic drive_idle();
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_lock = 0; bus.r0_addr = '0; bus.r0_byteena = '0; bus.r0_wdata = '0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_lock = 0; bus.r1_addr = '0; bus.r1_byteena = '0; bus.r1_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 17;
  vec_t vecs [NV];
  logic [255:0] W0, P2, ALL1, MASK, M2;

  initial begin
    checks = 0;
    errors = 0;
    W0   = 256'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000;
    P2   = {8{32'h1234_5678}};
    ALL1 = '1;
    MASK = 256'h0000_FFFF_0000_0000;
    M2   = (P2 & ~MASK) | MASK;

    //               r0 q we addr  r1 q we addr  be         wd    g0 g1 v0 v1 c  rdata
    vecs[0]  = mk(1, 1, 14'd0, 0, 0, 14'd0, 32'hFFFF_FFFF, W0,   1, 0, 0, 0, 0, '0);
    vecs[1]  = mk(1, 0, 14'd0, 0, 0, 14'd0, 32'h0,         '0,   1, 0, 0, 0, 0, '0);
    vecs[2]  = mk(0, 0, 14'd0, 0, 0, 14'd0, 32'h0,         '0,   0, 0, 0, 0, 0, '0);
    vecs[3]  = mk(0, 0, 14'd0, 0, 0, 14'd0, 32'h0,         '0,   0, 0, 1, 0, 1, W0);
    vecs[4]  = mk(0, 0, 14'd0, 1, 1, 14'd2, 32'hFFFF_FFFF, P2,   0, 1, 0, 0, 0, '0);
    vecs[5]  = mk(1, 1, 14'd2, 0, 0, 14'd0, 32'h0000_0030, ALL1, 1, 0, 0, 0, 0, '0);
    vecs[6]  = mk(1, 0, 14'd2, 0, 0, 14'd0, 32'h0,         '0,   1, 0, 0, 0, 0, '0);
    vecs[7]  = mk(0, 0, 14'd0, 0, 0, 14'd0, 32'h0,         '0,   0, 0, 0, 0, 0, '0);
    vecs[8]  = mk(0, 0, 14'd0, 0, 0, 14'd0, 32'h0,         '0,   0, 0, 1, 0, 1, M2);
    vecs[9]  = mk(0, 0, 14'd0, 1, 0, 14'd0, 32'h0,         '0,   0, 1, 0, 0, 0, '0);
    vecs[10] = mk(1, 0, 14'd0, 1, 0, 14'd2, 32'h0,         '0,   1, 0, 0, 0, 0, '0);
    vecs[11] = mk(1, 0, 14'd2, 1, 0, 14'd2, 32'h0,         '0,   0, 1, 0, 1, 1, W0);
    vecs[12] = mk(1, 0, 14'd2, 1, 0, 14'd0, 32'h0,         '0,   1, 0, 1, 0, 1, W0);
    vecs[13] = mk(0, 0, 14'd0, 1, 0, 14'd0, 32'h0,         '0,   0, 1, 0, 1, 1, M2);
    vecs[14] = mk(0, 0, 14'd0, 0, 0, 14'd0, 32'h0,         '0,   0, 0, 1, 0, 1, M2);
    vecs[15] = mk(0, 0, 14'd0, 0, 0, 14'd0, 32'h0,         '0,   0, 0, 0, 1, 1, W0);
    vecs[16] = mk(0, 0, 14'd0, 0, 0, 14'd0, 32'h0,         '0,   0, 0, 0, 0, 0, '0);

    // Reset: outputs quiet even with a request pending.
    drive_idle();
    reset = 1'b0;
    bus.r0_req = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", 256'(bus.r0_gnt), 256'(0));
    chk("rst_gnt1", 256'(bus.r1_gnt), 256'(0));
    chk("rst_rden", 256'(bus.ram_rden), 256'(0));
    chk("rst_wren", 256'(bus.ram_wren), 256'(0));
    chk("rst_be",   256'(bus.ram_byteena), 256'(0));
    chk("rst_rv",   256'({bus.r0_rvalid, bus.r1_rvalid}), 256'(0));
    next_cycle();
    drive_idle();
    reset = 1'b1;
    next_cycle();

    // Table-driven single-beat traffic.
    for (int i = 0; i < NV; i++) begin
      logic gr;
      logic [255:0] ex_addr, ex_be, ex_wd;
      bus.r0_req = vecs[i].r0_req; bus.r0_we = vecs[i].r0_we; bus.r0_addr = vecs[i].r0_addr;
      bus.r1_req = vecs[i].r1_req; bus.r1_we = vecs[i].r1_we; bus.r1_addr = vecs[i].r1_addr;
      bus.r0_lock = 0; bus.r1_lock = 0;
      bus.r0_byteena = vecs[i].be; bus.r1_byteena = vecs[i].be;
      bus.r0_wdata = vecs[i].wd;   bus.r1_wdata = vecs[i].wd;
      @(negedge clk);
      gr = vecs[i].g0 | vecs[i].g1;
      ex_addr = gr ? 256'(vecs[i].g0 ? vecs[i].r0_addr : vecs[i].r1_addr) : '0;
      ex_be   = gr ? 256'(vecs[i].be) : '0;
      ex_wd   = gr ? vecs[i].wd : '0;
      chk($sformatf("v%0d_gnt0", i), 256'(bus.r0_gnt), 256'(vecs[i].g0));
      chk($sformatf("v%0d_gnt1", i), 256'(bus.r1_gnt), 256'(vecs[i].g1));
      chk($sformatf("v%0d_rv0", i), 256'(bus.r0_rvalid), 256'(vecs[i].v0));
      chk($sformatf("v%0d_rv1", i), 256'(bus.r1_rvalid), 256'(vecs[i].v1));
      chk($sformatf("v%0d_wren", i), 256'(bus.ram_wren),
          256'((vecs[i].g0 & vecs[i].r0_we) | (vecs[i].g1 & vecs[i].r1_we)));
      chk($sformatf("v%0d_rden", i), 256'(bus.ram_rden),
          256'((vecs[i].g0 & ~vecs[i].r0_we) | (vecs[i].g1 & ~vecs[i].r1_we)));
      chk($sformatf("v%0d_addr", i), 256'(bus.ram_address), ex_addr);
      chk($sformatf("v%0d_be", i), 256'(bus.ram_byteena), ex_be);
      chk($sformatf("v%0d_wd", i), bus.ram_writeData, ex_wd);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].rd);
      next_cycle();
    end
    drive_idle();

    // Locked r1 burst of 10 reads with r0 contending from the second beat.
    begin
      logic [13:0] eg0, eg1, ev0, ev1;
      int  left;
      logic r0_done;
      eg1 = 14'b00_1100_1111_1111;
      eg0 = 14'b00_0010_0000_0000;
      ev1 = 14'b11_0011_1111_1100;
      ev0 = 14'b00_1000_0000_0000;
      left = 10;
      r0_done = 1'b0;
      for (int c = 0; c < 14; c++) begin
        bus.r1_req  = (left > 0);
        bus.r1_lock = (left > 1);
        bus.r1_addr = 14'd0;
        bus.r0_req  = (c >= 1) && !r0_done;
        bus.r0_addr = 14'd2;
        @(negedge clk);
        chk($sformatf("lk%0d_gnt0", c), 256'(bus.r0_gnt), 256'(eg0[c]));
        chk($sformatf("lk%0d_gnt1", c), 256'(bus.r1_gnt), 256'(eg1[c]));
        chk($sformatf("lk%0d_rv0", c), 256'(bus.r0_rvalid), 256'(ev0[c]));
        chk($sformatf("lk%0d_rv1", c), 256'(bus.r1_rvalid), 256'(ev1[c]));
        if (bus.r1_gnt && left > 0) left--;
        if (bus.r0_gnt) r0_done = 1'b1;
        next_cycle();
      end
      drive_idle();
    end

    // Reset one cycle after two read grants: in-flight reads vanish.
    bus.r0_req = 1; bus.r0_addr = 14'd0;
    @(negedge clk);
    chk("mr_gnt0", 256'(bus.r0_gnt), 256'(1));
    next_cycle();
    bus.r0_req = 0; bus.r1_req = 1; bus.r1_addr = 14'd2;
    @(negedge clk);
    chk("mr_gnt1", 256'(bus.r1_gnt), 256'(1));
    next_cycle();
    drive_idle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mr%0d_rv", c), 256'({bus.r0_rvalid, bus.r1_rvalid}), 256'(0));
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    // First tie after reset goes to r0, then r1's read returns at +2.
    bus.r0_req = 1; bus.r0_addr = 14'd0; bus.r1_req = 1; bus.r1_addr = 14'd0;
    @(negedge clk);
    chk("pr_tie_gnt0", 256'(bus.r0_gnt), 256'(1));
    chk("pr_tie_gnt1", 256'(bus.r1_gnt), 256'(0));
    chk("pr_rv_none", 256'({bus.r0_rvalid, bus.r1_rvalid}), 256'(0));
    next_cycle();
    bus.r0_req = 0;
    @(negedge clk);
    chk("pr_gnt1", 256'(bus.r1_gnt), 256'(1));
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("pr_rv0_p2", 256'(bus.r0_rvalid), 256'(1));
    chk("pr_rv1_p1", 256'(bus.r1_rvalid), 256'(0));
    next_cycle();
    @(negedge clk);
    chk("pr_rv1_p2", 256'(bus.r1_rvalid), 256'(1));
    chk("pr_rdata", bus.rdata, W0);
    next_cycle();

    // Both requesters idle: RAM port stays quiet.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        chk($sformatf("id%0d_ctl", c),
            256'({bus.r0_gnt, bus.r1_gnt, bus.ram_rden, bus.ram_wren, bus.r0_rvalid, bus.r1_rvalid}), 256'(0));
        chk($sformatf("id%0d_be", c), 256'(bus.ram_byteena), 256'(0));
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
